// File: rtl/sap2_defs.sv
// Shared SAP-2 definitions: ALU op codes, operand-stage FSM encoding and default widths.
package sap2_defs;
  localparam int WIDTH_DEF = 8;
  localparam int SELW_DEF  = 4;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_DCR = 4'b0100;
  localparam logic [3:0] OP_INC = 4'b0101;
  localparam logic [3:0] OP_XOR = 4'b0110;
  localparam logic [3:0] OP_RAL = 4'b1110;
  localparam logic [3:0] OP_RAR = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;
endpackage

// File: rtl/alu_operand_stage.sv
// Register stage around the SAP-2 ALU: holds accumulator, TMP and flags, and
// sequences one ALU operation per accepted start (IDLE -> EXEC -> DONE).
module alu_operand_stage
  import sap2_defs::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SELW  = SELW_DEF
) (
  input  logic             CLK,
  input  logic             CLR_n,
  input  logic [WIDTH-1:0] WBUS_in,
  output logic [WIDTH-1:0] WBUS_out,
  input  logic             La,
  input  logic             Lt,
  input  logic             Ea,
  input  logic             start,
  input  logic [SELW-1:0]  op,
  input  logic             dst,
  output logic [WIDTH-1:0] accumulator,
  output logic [WIDTH-1:0] tmp,
  output logic [SELW-1:0]  Sel,
  output logic             Eu,
  input  logic [WIDTH-1:0] alu_result,
  input  logic [1:0]       alu_flags,
  output logic [1:0]       flags,
  output logic             busy,
  output logic             done,
  output logic             err
);

  state_e           state_q;
  logic [WIDTH-1:0] acc_q, tmp_q;
  logic [1:0]       flags_q;
  logic [SELW-1:0]  sel_q;
  logic             dst_q, eu_q, done_q, err_q;

  function automatic logic op_legal(input logic [SELW-1:0] o);
    case (o)
      SELW'(OP_ADD), SELW'(OP_SUB), SELW'(OP_AND), SELW'(OP_OR),
      SELW'(OP_DCR), SELW'(OP_INC), SELW'(OP_XOR),
      SELW'(OP_RAL), SELW'(OP_RAR): op_legal = 1'b1;
      default:                      op_legal = 1'b0;
    endcase
  endfunction

  // Loads share the start edge so EXEC already sees the freshly loaded operands.
  always_ff @(posedge CLK or negedge CLR_n) begin
    if (!CLR_n) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      tmp_q   <= '0;
      flags_q <= '0;
      sel_q   <= '0;
      dst_q   <= 1'b0;
      eu_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (La) acc_q <= WBUS_in;
          if (Lt) tmp_q <= WBUS_in;
          if (start) begin
            if (op_legal(op)) begin
              sel_q   <= op;
              dst_q   <= dst;
              eu_q    <= 1'b1;
              state_q <= ST_EXEC;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        ST_EXEC: begin
          if (dst_q) tmp_q <= alu_result;
          else       acc_q <= alu_result;
          // Rotates (op[3] set) leave the flags untouched.
          if (!sel_q[3]) flags_q <= alu_flags;
          eu_q    <= 1'b0;
          done_q  <= 1'b1;
          state_q <= ST_DONE;
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign accumulator = acc_q;
  assign tmp         = tmp_q;
  assign flags       = flags_q;
  assign Sel         = sel_q;
  assign Eu          = eu_q;
  assign done        = done_q;
  assign err         = err_q;
  assign busy        = (state_q != ST_IDLE);
  assign WBUS_out    = Ea ? acc_q : {WIDTH{1'bz}};

endmodule

// File: tb/tb_alu_operand_stage.sv
// Scoreboard bench for alu_operand_stage: stimulus pushes expected register state,
// a negedge monitor pops and compares on done/err; the ALU itself is modelled here.
module tb_alu_operand_stage;

  logic       CLK = 1'b0;
  logic       CLR_n;
  logic [7:0] WBUS_in;
  wire  [7:0] WBUS_out;
  logic       La, Lt, Ea, start, dst;
  logic [3:0] op;
  logic [7:0] accumulator, tmp;
  logic [3:0] Sel;
  logic       Eu;
  logic [7:0] alu_result;
  logic [1:0] alu_flags;
  logic [1:0] flags;
  logic       busy, done, err;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    bit         is_err;
    logic [3:0] op;
    logic [7:0] acc;
    logic [7:0] tmp;
    logic [1:0] flags;
  } exp_t;
  exp_t exp_q[$];

  logic [7:0] m_acc, m_tmp;
  logic [1:0] m_flags;

  alu_operand_stage #(.WIDTH(8), .SELW(4)) dut (
    .CLK(CLK), .CLR_n(CLR_n), .WBUS_in(WBUS_in), .WBUS_out(WBUS_out),
    .La(La), .Lt(Lt), .Ea(Ea), .start(start), .op(op), .dst(dst),
    .accumulator(accumulator), .tmp(tmp), .Sel(Sel), .Eu(Eu),
    .alu_result(alu_result), .alu_flags(alu_flags), .flags(flags),
    .busy(busy), .done(done), .err(err)
  );

  always #5 CLK = ~CLK;

  // SAP-2 ALU behaviour: INC/DCR act on the tmp input, rotates on the accumulator.
  function automatic logic [7:0] alu_f(input logic [3:0] o, input logic [7:0] a, input logic [7:0] t);
    case (o)
      4'd0:    alu_f = a + t;
      4'd1:    alu_f = a - t;
      4'd2:    alu_f = a & t;
      4'd3:    alu_f = a | t;
      4'd4:    alu_f = t - 8'd1;
      4'd5:    alu_f = t + 8'd1;
      4'd6:    alu_f = a ^ t;
      4'd14:   alu_f = {a[6:0], a[7]};
      4'd15:   alu_f = {a[0], a[7:1]};
      default: alu_f = 8'h00;
    endcase
  endfunction

  always_comb begin
    alu_result = alu_f(Sel, accumulator, tmp);
    alu_flags  = {alu_result[7], alu_result == 8'h00};
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  always @(negedge CLK) begin
    if (CLR_n) begin
      if (Eu) begin
        if (exp_q.size() == 0) chk("eu_unexpected", 1, 0);
        else begin
          chk("exec_sel", Sel, exp_q[0].op);
          chk("exec_busy", busy, 1);
        end
      end
      if (done || err) begin
        if (exp_q.size() == 0) chk("unexpected_event", {done, err}, 0);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("event_kind", {done, err}, e.is_err ? 2'b01 : 2'b10);
          chk("acc", accumulator, e.acc);
          chk("tmp", tmp, e.tmp);
          chk("flags", flags, e.flags);
          chk("busy_at_event", busy, e.is_err ? 0 : 1);
        end
      end
    end
  end

  task automatic load(input logic la, input logic lt, input logic [7:0] v);
    @(posedge CLK); #1;
    La = la; Lt = lt; WBUS_in = v;
    if (la) m_acc = v;
    if (lt) m_tmp = v;
    @(posedge CLK); #1;
    La = 1'b0; Lt = 1'b0;
  endtask

  task automatic issue(input logic [3:0] o, input logic d, input logic la, input logic lt,
                       input logic [7:0] v, input logic poke);
    logic [7:0] r;
    bit legal;
    exp_t e;
    legal = (o inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd14, 4'd15});
    @(posedge CLK); #1;
    start = 1'b1; op = o; dst = d; La = la; Lt = lt; WBUS_in = v;
    if (la) m_acc = v;
    if (lt) m_tmp = v;
    if (legal) begin
      r = alu_f(o, m_acc, m_tmp);
      if (d) m_tmp = r; else m_acc = r;
      if (o < 4'd8) m_flags = {r[7], r == 8'h00};
    end
    e.is_err = !legal; e.op = o; e.acc = m_acc; e.tmp = m_tmp; e.flags = m_flags;
    exp_q.push_back(e);
    @(posedge CLK); #1;
    start = poke & legal; La = poke & legal; Lt = poke & legal;
    op = 4'($urandom); WBUS_in = 8'($urandom); dst = 1'($urandom);
    @(posedge CLK); #1;
    start = 1'b0; La = 1'b0; Lt = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    CLR_n = 1'b0; WBUS_in = '0; La = 0; Lt = 0; Ea = 0; start = 0; op = '0; dst = 0;
    m_acc = '0; m_tmp = '0; m_flags = '0;
    #2;
    chk("rst_acc", accumulator, 0);
    chk("rst_tmp", tmp, 0);
    chk("rst_flags", flags, 0);
    chk("rst_ctrl", {Sel, Eu, busy, done, err}, 0);
    #10 CLR_n = 1'b1;

    issue(4'd0, 1'b0, 1'b1, 1'b1, 8'h05, 1'b0);   // 5 + 5
    load(1, 1, 8'h05); load(1, 0, 8'h02);
    issue(4'd1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);   // 2 - 5 = FD
    load(1, 0, 8'h02);
    issue(4'd2, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);   // AND -> 0
    load(1, 0, 8'h0A);
    issue(4'd15, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);  // RAR keeps Z
    load(0, 1, 8'hFF);
    issue(4'd5, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);   // INC tmp wraps
    issue(4'd4, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);   // DCR tmp wraps
    issue(4'd7, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);   // illegal
    issue(4'd12, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);  // illegal

    for (int i = 0; i < 60; i++) begin
      logic [3:0] o;
      o = 4'($urandom_range(0, 15));
      if (o inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd14, 4'd15})
        issue(o, 1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom), 1'($urandom));
      else
        issue(o, 1'($urandom), 1'b0, 1'b0, 8'h00, 1'b0);
    end

    // Reset while EXEC is in flight: write-back and done pulse are lost.
    load(1, 0, 8'h33);
    @(posedge CLK); #1;
    start = 1'b1; op = 4'd0; dst = 1'b0;
    @(posedge CLK); #1;
    start = 1'b0;
    CLR_n = 1'b0;
    #1;
    chk("midexec_rst_acc", accumulator, 0);
    chk("midexec_rst_flags", flags, 0);
    chk("midexec_rst_eu_busy", {Eu, busy}, 0);
    m_acc = '0; m_tmp = '0; m_flags = '0;
    @(posedge CLK); #1;
    chk("midexec_no_done", done, 0);
    CLR_n = 1'b1;
    repeat (3) @(posedge CLK);
    #1;

    load(1, 0, 8'h5A);
    Ea = 1'b1; #1;
    chk("wbus_drive", WBUS_out, 8'h5A);
    Ea = 1'b0; #1;
    chk("wbus_release", (WBUS_out === 8'h5A), 0);

    issue(4'd6, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b0);   // XOR after drive test
    repeat (4) @(posedge CLK);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
